// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one word read at a time to instruction memory and hands
// each fetched word plus its PC to decode; redirects flush the current fetch.
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          PC_INC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              req_valid_q, req_valid_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_out_q, instr_out_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [31:0]       fetch_count_q, fetch_count_d;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            req_valid_q   <= 1'b1;
            instr_valid_q <= 1'b0;
            instr_out_q   <= '0;
            instr_pc_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            instr_out_q   <= instr_out_d;
            instr_pc_q    <= instr_pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        instr_out_d   = instr_out_q;
        instr_pc_d    = instr_pc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // The old address was accepted; its response must be thrown away.
                    if (imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_rsp_valid) begin
                    if (drop_q || redirect_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        instr_out_d   = imem_rsp_data;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d          = redirect_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end else if (instr_ready) begin
                    pc_d          = pc_q + ADDR_W'(PC_INC);
                    fetch_count_d = fetch_count_q + 32'd1;
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        req_valid_d = (state_d == S_REQ);
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr_out      = instr_out_q;
    assign instr_pc       = instr_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a behavioural memory answers requests with a
// configurable latency and a monitor records every delivered instruction.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_out, instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_count;

    logic        req_valid_40, instr_valid_40;
    logic [31:0] imem_addr_40, instr_out_40, instr_pc_40, fetch_count_40;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int lat_fixed  = 1;
    bit rand_lat   = 1'b0;
    bit rand_ready = 1'b0;

    logic [31:0] q_pc[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(1)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count)
    );

    // Second instance only observed right after reset, to see RESET_PC take effect.
    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h40), .PC_INC(1)) u_dut40 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid_40), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr_40),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid_40), .instr_ready(instr_ready),
        .instr_out(instr_out_40), .instr_pc(instr_pc_40),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_count(fetch_count_40)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h00500093;
            32'd1:   return 32'h00300113;
            32'd2:   return 32'h002081b3;
            32'd3:   return 32'h00a00213;
            32'd4:   return 32'h004182b3;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: decides ready and returns data at the negedge, away from the DUT edge.
    initial begin
        bit          pending = 1'b0;
        int          cnt = 0;
        logic [31:0] paddr = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_rsp_valid = 1'b0;
            if (rst) begin
                pending = 1'b0;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(paddr);
                    pending        = 1'b0;
                end
            end
            imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rst && imem_req_valid) begin
                checks++;
                if (pending) begin
                    errors++;
                    $display("FAIL outstanding: request valid at addr %h while %h still pending", imem_addr, paddr);
                end
                if (imem_req_ready) begin
                    pending = 1'b1;
                    cnt     = rand_lat ? $urandom_range(1, 5) : lat_fixed;
                    paddr   = imem_addr;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && !redirect_valid && instr_valid && instr_ready) begin
            q_pc.push_back(instr_pc);
            q_data.push_back(instr_out);
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_pc.delete();
        q_data.delete();
        q_cyc.delete();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 50) begin tick(); n++; end
        checks++;
        if (!instr_valid) begin errors++; $display("FAIL %s: instr_valid got 0 want 1 (timeout)", name); end
    endtask

    task automatic wait_req(input string name, input bit level);
        int n = 0;
        while (imem_req_valid !== level && n < 50) begin tick(); n++; end
        checks++;
        if (imem_req_valid !== level) begin errors++; $display("FAIL %s: imem_req_valid got %b want %b (timeout)", name, imem_req_valid, level); end
    endtask

    task automatic wait_deliveries(input string name, input int num, input int budget);
        int n = 0;
        while (q_pc.size() < num && n < budget) begin tick(); n++; end
        checks++;
        if (q_pc.size() < num) begin errors++; $display("FAIL %s: deliveries got %0d want %0d (timeout)", name, q_pc.size(), num); end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        checks++;
        if ({imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc, fetch_count} !== {1'b1, 32'h0, 1'b0, 96'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b addr=%h v=%b out=%h pc=%h cnt=%0d want 1/0/0/0/0/0",
                     imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc, fetch_count);
        end
        checks++;
        if ({req_valid_40, imem_addr_40} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL reset_pc_param: got req=%b addr=%h want 1/00000040", req_valid_40, imem_addr_40);
        end
    endtask

    task automatic test_stream();
        rst = 1'b1; tick(); clear_q(); rst = 1'b0;
        wait_deliveries("stream", 5, 100);
        checks++;
        if (fetch_count !== 32'd5) begin errors++; $display("FAIL stream_count: got %0d want 5", fetch_count); end
        for (int i = 0; i < 5 && i < q_pc.size(); i++) begin
            checks++;
            if (q_pc[i] !== 32'(i) || q_data[i] !== mem_word(32'(i))) begin
                errors++;
                $display("FAIL stream_word%0d: got pc=%h data=%h want pc=%h data=%h", i, q_pc[i], q_data[i], i, mem_word(32'(i)));
            end
            if (i > 0) begin
                checks++;
                if (q_cyc[i] - q_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL stream_rate%0d: got %0d cycles want 3", i, q_cyc[i] - q_cyc[i-1]);
                end
            end
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] hpc, hout, fc0;
        wait_valid("bp_hold");
        hpc = instr_pc; hout = instr_out; fc0 = fetch_count;
        checks++;
        if (hout !== mem_word(hpc)) begin errors++; $display("FAIL bp_data: got %h want %h", hout, mem_word(hpc)); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({instr_valid, instr_out, instr_pc, imem_req_valid} !== {1'b1, hout, hpc, 1'b0}) begin
                errors++;
                $display("FAIL bp_stable%0d: got v=%b out=%h pc=%h req=%b want 1/%h/%h/0", i, instr_valid, instr_out, instr_pc, imem_req_valid, hout, hpc);
            end
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if ({instr_valid, imem_req_valid, imem_addr, fetch_count} !== {1'b0, 1'b1, hpc + 32'd1, fc0 + 32'd1}) begin
            errors++;
            $display("FAIL bp_release: got v=%b req=%b addr=%h cnt=%0d want 0/1/%h/%0d", instr_valid, imem_req_valid, imem_addr, fetch_count, hpc + 32'd1, fc0 + 32'd1);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] fc0;
        lat_fixed = 3;
        wait_req("rw_enter_wait", 1'b0);
        fc0 = fetch_count;
        clear_q();
        redirect_valid = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0; lat_fixed = 1;
        checks++;
        if ({imem_req_valid, imem_addr} !== {1'b0, 32'h10}) begin
            errors++;
            $display("FAIL rw_pc: got req=%b addr=%h want 0/00000010", imem_req_valid, imem_addr);
        end
        wait_req("rw_new_req", 1'b1);
        checks++;
        if (imem_addr !== 32'h10) begin errors++; $display("FAIL rw_req_addr: got %h want 00000010", imem_addr); end
        wait_deliveries("rw_deliver", 1, 30);
        checks++;
        if (q_pc.size() > 0 && (q_pc[0] !== 32'h10 || q_data[0] !== mem_word(32'h10) || fetch_count !== fc0 + 32'd1)) begin
            errors++;
            $display("FAIL rw_word: got pc=%h data=%h cnt=%0d want 00000010/%h/%0d", q_pc[0], q_data[0], fetch_count, mem_word(32'h10), fc0 + 32'd1);
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_redirect_hold();
        logic [31:0] fc0;
        wait_valid("rh_hold");
        fc0 = fetch_count;
        instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if ({instr_valid, imem_req_valid, imem_addr, fetch_count} !== {1'b0, 1'b1, 32'h20, fc0}) begin
            errors++;
            $display("FAIL rh_flush: got v=%b req=%b addr=%h cnt=%0d want 0/1/00000020/%0d", instr_valid, imem_req_valid, imem_addr, fetch_count, fc0);
        end
        clear_q();
        wait_deliveries("rh_deliver", 1, 30);
        checks++;
        if (q_pc.size() > 0 && q_pc[0] !== 32'h20) begin errors++; $display("FAIL rh_word: got pc=%h want 00000020", q_pc[0]); end
    endtask

    task automatic test_random();
        int n = 0;
        rst = 1'b1; tick(); clear_q(); rst = 1'b0;
        rand_ready = 1'b1; rand_lat = 1'b1;
        while (q_pc.size() < 200 && n < 6000) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checks++;
        if (q_pc.size() != 200 || fetch_count !== 32'd200) begin
            errors++;
            $display("FAIL rand_count: got %0d deliveries cnt=%0d want 200/200", q_pc.size(), fetch_count);
        end
        for (int i = 0; i < q_pc.size(); i++) begin
            checks++;
            if (q_pc[i] !== 32'(i) || q_data[i] !== mem_word(32'(i))) begin
                errors++;
                $display("FAIL rand_word%0d: got pc=%h data=%h want pc=%h data=%h", i, q_pc[i], q_data[i], i, mem_word(32'(i)));
            end
        end
        rand_ready = 1'b0; rand_lat = 1'b0; instr_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        lat_fixed = 5; instr_ready = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        wait_req("rm_enter_wait", 1'b0);
        rst = 1'b1; tick();
        checks++;
        if ({imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc, fetch_count, req_valid_40, imem_addr_40} !==
            {1'b1, 32'h0, 1'b0, 96'h0, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL rm_wait_reset: got req=%b addr=%h v=%b out=%h pc=%h cnt=%0d addr40=%h",
                     imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc, fetch_count, imem_addr_40);
        end
        rst = 1'b0;
        wait_valid("rm_hold");
        checks++;
        if ({instr_pc, instr_out} !== {32'h0, mem_word(32'h0)}) begin
            errors++;
            $display("FAIL rm_first_after_reset: got pc=%h out=%h want 00000000/%h", instr_pc, instr_out, mem_word(32'h0));
        end
        rst = 1'b1; tick();
        checks++;
        if ({imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc, fetch_count} !== {1'b1, 32'h0, 1'b0, 96'h0}) begin
            errors++;
            $display("FAIL rm_hold_reset: got req=%b addr=%h v=%b out=%h pc=%h cnt=%0d want 1/0/0/0/0/0",
                     imem_req_valid, imem_addr, instr_valid, instr_out, instr_pc, fetch_count);
        end
        rst = 1'b0; lat_fixed = 1; instr_ready = 1'b1;
        clear_q();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        wait_deliveries("rm_wrap_deliver", 1, 30);
        checks++;
        if (q_pc.size() > 0 && (q_pc[0] !== 32'hFFFF_FFFF || q_data[0] !== mem_word(32'hFFFF_FFFF))) begin
            errors++;
            $display("FAIL rm_wrap_word: got pc=%h data=%h want ffffffff/%h", q_pc[0], q_data[0], mem_word(32'hFFFF_FFFF));
        end
        checks++;
        if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL rm_wrap_pc: got req=%b addr=%h want 1/00000000", imem_req_valid, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
